adder_tree_accum: RTL and testbench
===================================

Name: adder_tree_accum

Overview:
- Sequential consumer placed directly downstream of the final adder-tree level. The adder tree is purely combinational.
- Accepts one tree sum per cycle under a valid/ready handshake and accumulates the sums over a frame delimited by in_last.
- At the end of each frame, presents the frame total, beat count and overflow flag in a single registered output slot with valid/ready backpressure.

Parameters:
- IN_WIDTH, 8: width of the tree sum on in_data, unsigned.
- ACC_WIDTH, 16: accumulator and out_sum width. Must be >= IN_WIDTH; the implementation fails elaboration with $fatal otherwise.
- CNT_WIDTH, 16: beat counter and out_count width. Must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data and in_last are valid this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  IN_WIDTH  unsigned tree sum.
- in_last  input  1  this beat closes the frame.
- out_valid  output  1  out_sum, out_count and out_ovf hold a completed frame.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_WIDTH  frame total.
- out_count  output  CNT_WIDTH  number of beats in the frame.
- out_ovf  output  1  sticky: the accumulator overflowed at some point during the frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Reset overrides every other event, including a mid-frame beat or an unconsumed result; the partial frame and the pending result are discarded.
- Handshake rules:
  - in_ready = !(out_valid && !out_ready). It is combinational on out_ready and independent of in_valid.
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_valid must not depend on in_ready.
- States:
  - IDLE: no frame open; acc=0, cnt=0.
  - ACCUM: a frame is open.
- Accepted beat with in_last=0:
  - acc <= acc + zero-extended in_data (modulo 2^ACC_WIDTH).
  - ovf <= ovf | carry-out of that addition.
  - cnt <= cnt + 1, wrapping modulo 2^CNT_WIDTH.
  - state <= ACCUM.
- Accepted beat with in_last=1, from either state:
  - out_sum <= acc + in_data, with the same overflow rule.
  - out_count <= cnt + 1.
  - out_ovf <= ovf | carry.
  - out_valid <= 1.
  - acc, cnt and ovf clear to 0; state <= IDLE.
  - A single-beat frame in IDLE gives out_count=1.
- Latency: the result appears one cycle after the in_last beat is accepted.
- Output slot behaviour:
  - Consumed with no new last beat in the same cycle: out_valid <= 0 next cycle; out_sum, out_count and out_ovf keep their last values.
  - Consumed and a new last beat accepted in the same cycle: the slot reloads and out_valid stays 1. This gives back-to-back single-beat frames at full rate, one per cycle.
  - Not consumed (out_valid=1, out_ready=0): out_sum, out_count and out_ovf are held stable. in_ready=0, so accumulation stalls.
- in_valid=0 cycles: no state change. Gaps inside a frame are allowed.

Optional Feature:
- Macro: ADDER_TREE_ACCUM_SAT_EN.
- When defined:
  - The accumulator saturates at 2^ACC_WIDTH-1 instead of wrapping.
  - Once saturated, it stays at all-ones for the rest of the frame.
  - out_ovf behaves exactly as without the macro (set when saturation occurs).
  - The counter still wraps.
- When undefined: the accumulator wraps modulo 2^ACC_WIDTH as described in Behaviour.

Test Plan:
- Reset checks:
  - Hold rst 3 cycles -> out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
  - Assert rst mid-frame -> partial sum discarded; the next frame {9, last} gives out_sum=9, out_count=1.
- Four-beat frame: defaults, beats 3, 5, 7, 10 (10 with in_last), out_ready=1 -> one cycle later out_valid=1, out_sum=25, out_count=4, out_ovf=0; out_valid=0 the following cycle.
- Backpressure:
  - Complete frame {1, last}, out_ready=0 for 5 cycles while in_valid=1 with {2,2,last} -> in_ready=0 throughout; out_sum stays 1.
  - Then raise out_ready -> second frame is accepted; out_sum=4, out_count=2.
- Back-to-back single-beat frames 4, 6, 8 on consecutive cycles with out_ready=1 -> out_valid high 3 consecutive cycles with out_sum 4, 6, 8 and out_count=1 each.
- Overflow, ACC_WIDTH=8, IN_WIDTH=8, frame 200, 100, 50 (last):
  - Without the macro -> out_sum=94, out_ovf=1.
  - With ADDER_TREE_ACCUM_SAT_EN -> out_sum=255, out_ovf=1.
- Gaps: frame 2, gap 3 cycles with in_valid=0, 2, gap, 2 (last) -> out_sum=6, out_count=3. Then the next frame {5, last} -> out_ovf=0 and out_sum=5, confirming clear between frames.

Source files
------------

// File: rtl/adder_tree_accum_if.sv
// Handshake bundle for adder_tree_accum: the beat input channel and the frame-result output slot.
// The master side is the surrounding logic; the slave side is the accumulator itself.
interface adder_tree_accum_if #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;

    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_count,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_count,
        output out_ovf
    );

endinterface

// File: rtl/adder_tree_accum.sv
// Frame accumulator behind a combinational adder tree: sums beats until in_last, then
// presents total, beat count and sticky overflow in one registered slot.
// Optional: define ADDER_TREE_ACCUM_SAT_EN to saturate the accumulator instead of wrapping.
module adder_tree_accum #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    adder_tree_accum_if.slave  bus
);

    if (ACC_WIDTH < IN_WIDTH) begin : g_bad_acc_width
        $fatal(1, "adder_tree_accum: ACC_WIDTH (%0d) must be >= IN_WIDTH (%0d)", ACC_WIDTH, IN_WIDTH);
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $fatal(1, "adder_tree_accum: CNT_WIDTH (%0d) must be >= 1", CNT_WIDTH);
    end

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    state_e               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf;

    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] out_sum_q;
    logic [CNT_WIDTH-1:0] out_count_q;
    logic                 out_ovf_q;

    logic                 in_ready;
    logic                 beat_accept;
    logic                 result_take;

    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 carry;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0] cnt_next;

    // The slot can take a new result whenever it is empty or being drained this cycle.
    assign in_ready    = !(out_valid_q && !bus.out_ready);
    assign beat_accept = bus.in_valid && in_ready;
    assign result_take = out_valid_q && bus.out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_base = '0;
        if (state == ACCUM) begin
            acc_base = acc;
        end
        sum_wide = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, bus.in_data};
        carry    = sum_wide[ACC_WIDTH];
`ifdef ADDER_TREE_ACCUM_SAT_EN
        acc_next = carry ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
`else
        acc_next = sum_wide[ACC_WIDTH-1:0];
`endif
        cnt_next = cnt + CNT_WIDTH'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (result_take) begin
                out_valid_q <= 1'b0;
            end
            if (beat_accept) begin
                if (bus.in_last) begin
                    // A closing beat reloads the slot even if it is being drained in the same cycle.
                    out_sum_q   <= acc_next;
                    out_count_q <= cnt_next;
                    out_ovf_q   <= ovf | carry;
                    out_valid_q <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf         <= 1'b0;
                    state       <= IDLE;
                end else begin
                    acc         <= acc_next;
                    cnt         <= cnt_next;
                    ovf         <= ovf | carry;
                    state       <= ACCUM;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Scoreboard bench for adder_tree_accum: a 16-bit and an 8-bit-accumulator / 4-bit-counter instance
// share one stimulus stream; a frame-level model predicts each result, a monitor checks it.
module tb_adder_tree_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = '0;

    always #5 clk = ~clk;

    adder_tree_accum_if #(.IN_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(16)) bus16 ();
    adder_tree_accum_if #(.IN_WIDTH(8), .ACC_WIDTH(8),  .CNT_WIDTH(4))  bus8 ();

    assign bus16.in_valid  = in_valid;
    assign bus16.in_data   = in_data;
    assign bus16.in_last   = in_last;
    assign bus16.out_ready = out_ready;
    assign bus8.in_valid   = in_valid;
    assign bus8.in_data    = in_data;
    assign bus8.in_last    = in_last;
    assign bus8.out_ready  = out_ready;

    adder_tree_accum #(.IN_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    adder_tree_accum #(.IN_WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(4)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    typedef struct {
        longint total;
        int     beats;
    } frame_t;

    frame_t exp_q[$];
    longint frame_total = 0;
    int     frame_beats = 0;
    bit     slot_full   = 1'b0;
    int     tests = 0;
    int     fails = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Frame-level expectation: exact integer total reduced to the accumulator width.
    function automatic void expect_sum(input longint total, input int w, output longint s, output bit o);
        longint lim;
        lim = longint'(1) << w;
`ifdef ADDER_TREE_ACCUM_SAT_EN
        s = (total > lim - 1) ? lim - 1 : total;
        o = (total > lim - 1);
`else
        s = total % lim;
        o = (total >= lim);
`endif
    endfunction

    // One stimulus cycle: inputs set after a rising edge, handshake evaluated at the falling edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit last, input bit ordy);
        bit exp_rdy;
        bit acc;
        bit take;
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = !(slot_full && !ordy);
        check("in_ready16", bus16.in_ready, exp_rdy);
        check("in_ready8", bus8.in_ready, exp_rdy);
        acc  = v && exp_rdy;
        take = slot_full && ordy;
        if (acc) begin
            frame_total += longint'(d);
            frame_beats++;
            if (last) begin
                exp_q.push_back('{total: frame_total, beats: frame_beats});
                frame_total = 0;
                frame_beats = 0;
            end
        end
        if (acc && last) slot_full = 1'b1;
        else if (take)   slot_full = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        frame_total = 0;
        frame_beats = 0;
        slot_full   = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, bus16.out_valid, 0);
        check({tag, "_out_sum"},   bus16.out_sum,   0);
        check({tag, "_out_count"}, bus16.out_count, 0);
        check({tag, "_out_ovf"},   bus16.out_ovf,   0);
        check({tag, "_in_ready"},  bus16.in_ready,  1);
        check({tag, "_out_valid8"}, bus8.out_valid, 0);
        check({tag, "_out_sum8"},   bus8.out_sum,   0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle a result is presented it must match the head of the queue;
    // the head is retired only when the consumer takes it.
    always @(negedge clk) begin
        if (rst === 1'b0 && (bus16.out_valid === 1'b1 || bus8.out_valid === 1'b1)) begin
            check("out_valid_match", bus8.out_valid, bus16.out_valid);
            if (exp_q.size() == 0) begin
                check("unexpected_result", bus16.out_valid, 0);
            end else begin
                frame_t f;
                longint s;
                bit     o;
                f = exp_q[0];
                expect_sum(f.total, 16, s, o);
                check("out_sum16",   bus16.out_sum,   s);
                check("out_ovf16",   bus16.out_ovf,   o);
                check("out_count16", bus16.out_count, longint'(f.beats) % 65536);
                expect_sum(f.total, 8, s, o);
                check("out_sum8",    bus8.out_sum,    s);
                check("out_ovf8",    bus8.out_ovf,    o);
                check("out_count8",  bus8.out_count,  longint'(f.beats) % 16);
                if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        do_reset(3);
        check_idle_outputs("reset");

        // Four-beat frame.
        cycle(1, 3, 0, 1);
        cycle(1, 5, 0, 1);
        cycle(1, 7, 0, 1);
        cycle(1, 10, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Backpressure: held result blocks the next frame for five cycles.
        cycle(1, 1, 1, 0);
        repeat (5) cycle(1, 2, 0, 0);
        cycle(1, 2, 0, 1);
        cycle(1, 2, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Back-to-back single-beat frames.
        cycle(1, 4, 1, 1);
        cycle(1, 6, 1, 1);
        cycle(1, 8, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Overflow of the 8-bit accumulator.
        cycle(1, 200, 0, 1);
        cycle(1, 100, 0, 1);
        cycle(1, 50, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Gaps inside a frame, then a clean frame after it.
        cycle(1, 2, 0, 1);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(1, 2, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 2, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 5, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Reset mid-frame discards the partial sum.
        cycle(1, 3, 0, 1);
        cycle(1, 4, 0, 1);
        do_reset(1);
        cycle(1, 9, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Reset with an unconsumed result discards it.
        cycle(1, 7, 1, 0);
        cycle(0, 0, 0, 0);
        do_reset(1);
        check_idle_outputs("reset_pending");

        // Long frame: wraps the 4-bit counter and both accumulator flavours of the 8-bit instance.
        for (int i = 0; i < 20; i++) cycle(1, 255, (i == 19), 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Randomized traffic with random backpressure and gaps.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 8), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
        end

        // Close any open frame and drain the slot.
        cycle(1, 1, 1, 1);
        repeat (4) cycle(0, 0, 0, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
